// File: rtl/register_bus_reader.sv
// Read controller for a shared tristate register bus: selects one register, waits the settle
// time, captures the bus and returns it over valid/ready. Option: REGISTER_BUS_READER_AUTOSCAN_EN.
module register_bus_reader #(
  parameter int unsigned NrOfBits     = 8,
  parameter int unsigned NrOfRegs     = 4,
  parameter int unsigned AddrBits     = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                ReqValid,
  input  logic [AddrBits-1:0] ReqAddr,
  output logic                ReqReady,
  input  logic [NrOfBits-1:0] BusIn,
  output logic [NrOfRegs-1:0] cs,
  output logic                RspValid,
  output logic [NrOfBits-1:0] RspData,
  output logic                RspErr,
  input  logic                RspReady,
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
  input  logic                ScanEnable,
`endif
  output logic                Busy
);

  localparam logic [3:0] SettleInit = 4'(SettleCycles);

  typedef enum logic [1:0] {StIdle, StSelect, StRespond} state_e;

  state_e                state_q, state_d;
  logic [AddrBits-1:0]   addr_q, addr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [NrOfRegs-1:0]   cs_q, cs_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  en;
  logic                  issue_valid;
  logic [AddrBits-1:0]   issue_addr;
  logic [NrOfRegs-1:0]   issue_cs;
  logic                  addr_oor;

  // Active-low one-hot select; an index with no register decodes to all ones.
  function automatic logic [NrOfRegs-1:0] cs_decode(input logic [AddrBits-1:0] a);
    cs_decode = '1;
    for (int unsigned i = 0; i < NrOfRegs; i++) begin
      if (a == AddrBits'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

  assign en       = ClockEnable & Tick;
  assign issue_cs = cs_decode(issue_addr);
  assign addr_oor = &cs_decode(addr_q);

`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
  logic [AddrBits-1:0] scan_ptr_q, scan_ptr_d;
  logic                scan_q, scan_d;
  logic                issue_scan;

  // External requests win over the scanner in the same cycle.
  assign issue_scan  = ~ReqValid & ScanEnable;
  assign issue_valid = ReqValid | ScanEnable;
  assign issue_addr  = ReqValid ? ReqAddr : scan_ptr_q;
`else
  assign issue_valid = ReqValid;
  assign issue_addr  = ReqAddr;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
    scan_ptr_d  = scan_ptr_q;
    scan_d      = scan_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (en && issue_valid) begin
          addr_d  = issue_addr;
          cnt_d   = SettleInit;
          cs_d    = issue_cs;
          state_d = StSelect;
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
          scan_d  = issue_scan;
`endif
        end
      end
      StSelect: begin
        if (en) begin
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            rsp_data_d  = addr_oor ? '1 : BusIn;
            rsp_err_d   = addr_oor;
            rsp_valid_d = 1'b1;
            cs_d        = '1;
            state_d     = StRespond;
          end
        end
      end
      StRespond: begin
        if (en && RspReady) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
          if (scan_q) begin
            scan_ptr_d = (scan_ptr_q == AddrBits'(NrOfRegs - 1)) ? '0 : scan_ptr_q + 1'b1;
          end
          scan_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      cs_q        <= '1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      scan_ptr_q <= '0;
      scan_q     <= 1'b0;
    end else begin
      scan_ptr_q <= scan_ptr_d;
      scan_q     <= scan_d;
    end
  end
`endif

  assign cs       = cs_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign ReqReady = (state_q == StIdle);
  assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_register_bus_reader.sv
// Bench for register_bus_reader: two instances (settle 1 and 3) on modelled register banks,
// directed vector table, hand-written corner sequences and a randomized model comparison.
module tb_register_bus_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned SA = 1;
  localparam int unsigned SB = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          ClockEnable, Tick, ReqValid, RspReady;
  logic [AW-1:0] ReqAddr;
  logic [W-1:0]  bus_a, bus_b, data_a, data_b;
  logic [N-1:0]  cs_a, cs_b;
  logic          rdy_a, rdy_b, val_a, val_b, err_a, err_b, busy_a, busy_b;
  logic [W-1:0]  reg_val [N];
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
  logic          scan_en = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  // Register bank: each register drives the bus while its cs is low; released bus reads as 0.
  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int i = 0; i < N; i++) begin
      if (!cs_a[i]) bus_a = bus_a | reg_val[i];
      if (!cs_b[i]) bus_b = bus_b | reg_val[i];
    end
  end

  register_bus_reader #(
    .NrOfBits(W), .NrOfRegs(N), .AddrBits(AW), .SettleCycles(SA)
  ) u_dut_a (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(rdy_a), .BusIn(bus_a), .cs(cs_a),
    .RspValid(val_a), .RspData(data_a), .RspErr(err_a), .RspReady(RspReady),
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
    .ScanEnable(scan_en),
`endif
    .Busy(busy_a)
  );

  register_bus_reader #(
    .NrOfBits(W), .NrOfRegs(N), .AddrBits(AW), .SettleCycles(SB)
  ) u_dut_b (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(rdy_b), .BusIn(bus_b), .cs(cs_b),
    .RspValid(val_b), .RspData(data_b), .RspErr(err_b), .RspReady(RspReady),
`ifdef REGISTER_BUS_READER_AUTOSCAN_EN
    .ScanEnable(scan_en),
`endif
    .Busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Never more than one register may drive the bus.
  always @(negedge Clock) begin
    chk("onehot_a", 32'($countones(~cs_a) <= 1), 32'd1);
    chk("onehot_b", 32'($countones(~cs_b) <= 1), 32'd1);
  end

  // Transaction-level reference: a read is outstanding from acceptance until consumed; its
  // response is visible once s enabled edges have passed since acceptance.
  typedef struct {
    bit          have;
    int unsigned addr;
    int unsigned edges;
    logic [W-1:0] last;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input int unsigned s, input bit en,
                                    input bit rv, input int unsigned ra, input bit rr);
    mdl_t r = m;
    if (en) begin
      if (m.have) begin
        if (m.edges >= s) begin
          if (rr) r.have = 1'b0;
        end else begin
          r.edges = m.edges + 1;
          if (r.edges == s) r.last = (m.addr < N) ? reg_val[m.addr] : '1;
        end
      end else if (rv) begin
        r.have  = 1'b1;
        r.addr  = ra;
        r.edges = 0;
      end
    end
    return r;
  endfunction

  task automatic mdl_check(input string tag, input mdl_t m, input int unsigned s,
                           input logic [N-1:0] cs, input logic rdy, input logic val,
                           input logic err, input logic busy, input logic [W-1:0] data);
    logic         rsp;
    logic [N-1:0] exp_cs;
    rsp    = m.have && (m.edges >= s);
    exp_cs = '1;
    if (m.have && m.edges < s && m.addr < N) exp_cs[m.addr] = 1'b0;
    chk({tag, "_cs"},    32'(cs),   32'(exp_cs));
    chk({tag, "_rdy"},   32'(rdy),  32'(!m.have));
    chk({tag, "_busy"},  32'(busy), 32'(m.have));
    chk({tag, "_val"},   32'(val),  32'(rsp));
    chk({tag, "_err"},   32'(err),  32'(rsp && m.addr >= N));
    chk({tag, "_data"},  32'(data), 32'(m.last));
  endtask

  task automatic do_reset();
    Reset = 1'b1; ClockEnable = 1'b0; Tick = 1'b0;
    ReqValid = 1'b0; RspReady = 1'b0; ReqAddr = '0;
    @(posedge Clock); #1;
    chk("rst_cs",   32'(cs_a),   32'hF);
    chk("rst_rdy",  32'(rdy_a),  32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_val",  32'(val_a),  32'd0);
    chk("rst_err",  32'(err_a),  32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   period;
    logic [N-1:0]  exp_cs;
    logic [W-1:0]  exp_data;
    bit            exp_err;
    bit            use_b;
  } vec_t;

  // One read with Tick high every v.period-th cycle; checks cs hold, latency and response.
  task automatic dir_read(input vec_t v, input bit consume);
    bit          accepted = 0, got = 0, en, rdy;
    int unsigned edges = 0;
    int unsigned s = v.use_b ? SB : SA;
    ClockEnable = 1'b1; RspReady = 1'b0; ReqValid = 1'b1; ReqAddr = v.addr;
    for (int k = 0; k < 200 && !got; k++) begin
      Tick = (k % v.period == 0);
      en   = Tick;
      rdy  = v.use_b ? rdy_b : rdy_a;
      @(posedge Clock); #1;
      if (en) begin
        if (!accepted) begin
          if (rdy) begin accepted = 1; ReqValid = 1'b0; end
        end else begin
          edges++;
        end
      end
      if (accepted && !(v.use_b ? val_b : val_a))
        chk("sel_cs", 32'(v.use_b ? cs_b : cs_a), 32'(v.exp_cs));
      if (accepted && (v.use_b ? val_b : val_a)) got = 1;
    end
    chk("rsp_timeout", 32'(got),   32'd1);
    chk("latency",     edges,      s);
    chk("rsp_data",    32'(v.use_b ? data_b : data_a), 32'(v.exp_data));
    chk("rsp_err",     32'(v.use_b ? err_b : err_a),   32'(v.exp_err));
    chk("rsp_cs",      32'(v.use_b ? cs_b : cs_a),     32'hF);
    chk("rsp_rdy",     32'(v.use_b ? rdy_b : rdy_a),   32'd0);
    if (consume) begin
      Tick = 1'b1; RspReady = 1'b1;
      @(posedge Clock); #1;
      RspReady = 1'b0;
      chk("done_val",  32'(v.use_b ? val_b : val_a),   32'd0);
      chk("done_err",  32'(v.use_b ? err_b : err_a),   32'd0);
      chk("done_rdy",  32'(v.use_b ? rdy_b : rdy_a),   32'd1);
      chk("done_cs",   32'(v.use_b ? cs_b : cs_a),     32'hF);
      chk("done_data", 32'(v.use_b ? data_b : data_a), 32'(v.exp_data));
    end
  endtask

  vec_t vecs [8];

  initial begin
    mdl_t m_a, m_b;
    bit   en, rv, rr, acc;
    int unsigned ra;

    reg_val[0] = 8'h11; reg_val[1] = 8'h22; reg_val[2] = 8'h33; reg_val[3] = 8'h44;
    vecs[0] = '{3'd2, 1, 4'b1011, 8'h33, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 3, 4'b1011, 8'h33, 1'b0, 1'b0};
    vecs[2] = '{3'd5, 1, 4'b1111, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{3'd0, 2, 4'b1110, 8'h11, 1'b0, 1'b0};
    vecs[4] = '{3'd3, 1, 4'b0111, 8'h44, 1'b0, 1'b0};
    vecs[5] = '{3'd4, 2, 4'b1111, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{3'd1, 2, 4'b1101, 8'h22, 1'b0, 1'b1};
    vecs[7] = '{3'd6, 1, 4'b1111, 8'hFF, 1'b1, 1'b1};

    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].use_b) do_reset();
      dir_read(vecs[i], 1'b1);
    end

    // Back-pressured response: RspValid/RspData hold and new requests are ignored.
    do_reset();
    dir_read(vecs[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      ReqValid = k[0]; ReqAddr = 3'd1; Tick = 1'b1; RspReady = 1'b0;
      @(posedge Clock); #1;
      chk("hold_val",  32'(val_a),  32'd1);
      chk("hold_data", 32'(data_a), 32'h33);
      chk("hold_rdy",  32'(rdy_a),  32'd0);
      chk("hold_cs",   32'(cs_a),   32'hF);
    end
    ReqValid = 1'b0; RspReady = 1'b1;
    @(posedge Clock); #1;
    RspReady = 1'b0;
    chk("release_rdy", 32'(rdy_a), 32'd1);
    chk("release_val", 32'(val_a), 32'd0);

    // Back-to-back reads; dir_read checks the all-ones idle cycle between selects.
    dir_read('{3'd0, 1, 4'b1110, 8'h11, 1'b0, 1'b0}, 1'b1);
    dir_read('{3'd1, 1, 4'b1101, 8'h22, 1'b0, 1'b0}, 1'b1);

    // Asynchronous reset while register 0 is selected.
    ReqValid = 1'b1; ReqAddr = 3'd0; Tick = 1'b1;
    @(posedge Clock); #1;
    ReqValid = 1'b0; Tick = 1'b0;
    @(posedge Clock); #1;
    chk("midsel_cs",   32'(cs_a),   32'hE);
    chk("midsel_busy", 32'(busy_a), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_cs",   32'(cs_a),   32'hF);
    chk("arst_val",  32'(val_a),  32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_rdy",  32'(rdy_a),  32'd1);
    chk("arst_data", 32'(data_a), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Randomized traffic against the transaction model, both instances.
    do_reset();
    for (int i = 0; i < N; i++) reg_val[i] = 8'($urandom_range(255, 0));
    m_a = '{have: 1'b0, addr: 0, edges: 0, last: '0};
    m_b = m_a;
    ClockEnable = 1'b1; Tick = 1'b1; ReqValid = 1'b0; RspReady = 1'b0;
    for (int c = 0; c < 800; c++) begin
      en = ClockEnable && Tick; rv = ReqValid; ra = ReqAddr; rr = RspReady;
      @(posedge Clock);
      acc = en && rv && !m_a.have;
      m_a = mdl_step(m_a, SA, en, rv, ra, rr);
      m_b = mdl_step(m_b, SB, en, rv, ra, rr);
      #1;
      mdl_check("rnd_a", m_a, SA, cs_a, rdy_a, val_a, err_a, busy_a, data_a);
      mdl_check("rnd_b", m_b, SB, cs_b, rdy_b, val_b, err_b, busy_b, data_b);
      ClockEnable = ($urandom_range(7, 0) != 0);
      Tick        = ($urandom_range(2, 0) != 0);
      RspReady    = ($urandom_range(1, 0) != 0);
      if (!ReqValid || acc) begin
        ReqValid = ($urandom_range(1, 0) != 0);
        ReqAddr  = 3'($urandom_range(7, 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bus_reader.md
Name: register_bus_reader

Overview:
- Read-side controller for a shared tristate data bus driven by chip-selected register flip-flops.
- Each register drives the bus when its cs is 0 and releases it (high-Z) when its cs is 1.
- Accepts a read request for one register index, drives that register's cs low, waits a settle time, captures the bus, and returns the data over a valid/ready response channel.
- Sits between the CPU datapath or debug logic and a bank of bus-attached registers.

Parameters:
- NrOfBits, 8, bus and data width.
- NrOfRegs, 4, number of registers on the bus; one cs line each.
- AddrBits, 2, width of ReqAddr; must satisfy 2**AddrBits >= NrOfRegs.
- SettleCycles, 1, enabled cycles cs is held low before capture; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ClockEnable  in  1  global enable. State advances only on edges where ClockEnable&Tick=1 ("enabled edge").
- Tick  in  1  tick qualifier, as above.
- ReqValid  in  1  read request valid.
- ReqAddr  in  AddrBits  register index to read.
- ReqReady  out  1  request accepted on an enabled edge when ReqValid&ReqReady.
- BusIn  in  NrOfBits  shared tristate bus, sampled value.
- cs  out  NrOfRegs  per-register chip select; 0=drive bus, 1=release (high-Z).
- RspValid  out  1  response valid.
- RspData  out  NrOfBits  captured data.
- RspErr  out  1  address out of range; qualified by RspValid.
- RspReady  in  1  response consumed on an enabled edge when RspValid&RspReady.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-transaction:
  - State=IDLE.
  - cs=all ones; no register drives the bus.
  - RspValid=0, RspErr=0, RspData=0, ReqReady=1, Busy=0.
  - Settle counter=0.
- States: IDLE, SELECT, RESPOND. All transitions occur only on enabled edges. Non-enabled edges hold all state and outputs.
- IDLE:
  - ReqReady=1; cs all ones.
  - On ReqValid, latch ReqAddr, load counter=SettleCycles, go to SELECT.
- SELECT:
  - ReqReady=0.
  - cs[addr]=0 and all other bits 1; exactly one bit is low, registered, so no glitch.
  - Each enabled edge: if counter>1, decrement. Otherwise capture BusIn into RspData, set RspValid=1, set cs to all ones on the same edge, go to RESPOND.
- Out-of-range address (addr >= NrOfRegs):
  - No cs bit is driven low.
  - Still waits SettleCycles enabled edges.
  - Then RspData = all ones, RspErr=1.
- RESPOND:
  - RspValid=1; RspData and RspErr held stable.
  - cs all ones; ReqReady=0.
  - On RspReady: RspValid=0, RspErr=0, go to IDLE. RspData keeps its last value.
- Break-before-make: at least one enabled cycle (RESPOND plus IDLE) with cs all ones separates any two selects. Two cs bits are never low together.
- Latency: request accepted on enabled edge E0 → RspValid rises on enabled edge E0+SettleCycles.
- Minimum throughput: one read per SettleCycles+2 enabled edges.
- ReqValid is ignored outside IDLE; the requester holds it until accepted.
- RspReady is ignored outside RESPOND.

Optional Feature:
- Macro REGISTER_BUS_READER_AUTOSCAN_EN.
- When defined:
  - Adds input ScanEnable (1 bit).
  - In IDLE with ScanEnable=1 and ReqValid=0, the block self-issues a read of an internal scan pointer.
  - The pointer starts at 0 after reset, increments after each scan response is consumed, and wraps from NrOfRegs-1 to 0.
  - An external ReqValid has priority over a scan in the same cycle.
- When undefined: no ScanEnable port, no pointer logic; reads are issued only by requests.

Test Plan:
- Reset, then 4 register models drive 0x11, 0x22, 0x33, 0x44; ClockEnable=Tick=1, SettleCycles=1; request addr 2 → cs=4'b1011 for exactly 1 cycle, RspValid next edge with RspData=0x33, RspErr=0.
- Request addr 2 with Tick pulsing every 3rd cycle → cs=4'b1011 held across non-tick cycles, transitions only on tick edges, RspData=0x33.
- With AddrBits=3, request addr 5 → cs stays 4'b1111 throughout; RspData=0xFF, RspErr=1.
- Hold RspReady=0 for 5 cycles with ReqValid pulsing → RspValid and RspData stay stable, ReqReady=0, no new cs assertion; RspReady=1 → IDLE, ReqReady=1.
- Back-to-back reads of addr 0 then addr 1 → cs all ones for at least one cycle between 4'b1110 and 4'b1101; never two cs bits low simultaneously.
- Assert Reset during SELECT (cs=4'b1110) → cs=4'b1111 and RspValid=0 before the next clock edge; Busy=0.
